// File: rtl/key_load_pkg.sv
// key_load_pkg: shared types and helpers for the key delivery controller.
//   state_t  - controller FSM states
//   KEY_HDR  - frame header byte
//   nb()     - number of key bytes for a given key width
//   csum_upd - one step of the frame checksum
package key_load_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLoad    = 3'd1,
      StCheck   = 3'd2,
      StCommit  = 3'd3,
      StLockout = 3'd4
   } state_t;

   localparam logic [7:0] KEY_HDR = 8'hA5;

   function automatic int unsigned nb(input int unsigned key_w);
      return (key_w + 7) / 8;
   endfunction

   function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/key_shadow_reg.sv
// key_shadow_reg: byte-addressed staging register for an incoming key frame.
//   clk, rst_n   - clock, synchronous active-low reset
//   clr_i        - discard contents (new frame or failed frame)
//   wr_i, idx_i  - write data_i into byte slot idx_i
//   key_o        - staged key bits [KEY_W-1:0]
//   csum_o       - running XOR of all bytes written since clear
//   pad_ok_o     - padding bits above KEY_W are all zero
module key_shadow_reg
   import key_load_pkg::*;
#(
   parameter int unsigned KEY_W = 53,
   localparam int unsigned NB = nb(KEY_W),
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [IW-1:0]    idx_i,
   input  logic [7:0]       data_i,
   output logic [KEY_W-1:0] key_o,
   output logic [7:0]       csum_o,
   output logic             pad_ok_o
);

   logic [NB*8-1:0] shadow_q, shadow_d;
   logic [7:0]      csum_q, csum_d;

   always_comb begin
      shadow_d = shadow_q;
      csum_d   = csum_q;
      if (clr_i) begin
         shadow_d = '0;
         csum_d   = '0;
      end else if (wr_i) begin
         shadow_d[{idx_i, 3'b000} +: 8] = data_i;
         csum_d = csum_upd(csum_q, data_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q <= '0;
         csum_q   <= '0;
      end else begin
         shadow_q <= shadow_d;
         csum_q   <= csum_d;
      end
   end

   assign key_o    = shadow_q[KEY_W-1:0];
   assign csum_o   = csum_q;
   assign pad_ok_o = ((shadow_q >> KEY_W) == '0);

endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: receives framed key bytes over valid/ready, validates header,
// padding and checksum, then commits the key atomically onto key_out.
//   clk, rst_n  - clock, synchronous active-low reset
//   s_data/s_valid/s_ready - byte stream input
//   key_out     - committed key (drives keyinput<i> of the locked netlist)
//   key_loaded  - key_out holds a checked key
//   frame_err   - one-cycle pulse per rejected frame
//   locked_out  - sticky lockout after MAX_FAIL consecutive failures
module key_load_ctrl
   import key_load_pkg::*;
#(
   parameter int unsigned     KEY_W     = 53,
   parameter int unsigned     MAX_FAIL  = 3,
   parameter int unsigned     GAP_MAX   = 255,
   parameter logic [KEY_W-1:0] RESET_KEY = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [KEY_W-1:0] key_out,
   output logic             key_loaded,
   output logic             frame_err,
   output logic             locked_out
);

   localparam int unsigned NBYTES = nb(KEY_W);
   localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned FW = $clog2(MAX_FAIL + 1);
   localparam int unsigned GW = $clog2(GAP_MAX + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [FW-1:0]    fail_q, fail_d, fail_inc;
   logic [KEY_W-1:0] key_q, key_d;
   logic             loaded_q, loaded_d;
   logic             err_q, err_d;
   logic             lock_q, lock_d;
   logic             ready_q, ready_d;

   logic             xfer, frame_fail, sh_clr, sh_wr, pad_ok;
   logic [KEY_W-1:0] sh_key;
   logic [7:0]       sh_csum;

   key_shadow_reg #(
      .KEY_W(KEY_W)
   ) u_shadow (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (sh_clr),
      .wr_i    (sh_wr),
      .idx_i   (cnt_q),
      .data_i  (s_data),
      .key_o   (sh_key),
      .csum_o  (sh_csum),
      .pad_ok_o(pad_ok)
   );

   assign xfer     = s_valid && ready_q;
   assign fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      fail_d     = fail_q;
      key_d      = key_q;
      loaded_d   = loaded_q;
      err_d      = 1'b0;
      lock_d     = lock_q;
      sh_clr     = 1'b0;
      sh_wr      = 1'b0;
      frame_fail = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Non-header bytes are dropped without counting as failures.
            if (xfer && (s_data == KEY_HDR)) begin
               state_d = StLoad;
               cnt_d   = '0;
               gap_d   = '0;
               sh_clr  = 1'b1;
            end
         end
         StLoad, StCheck: begin
            if (xfer) begin
               gap_d = '0;
               if (state_q == StLoad) begin
                  sh_wr = 1'b1;
                  if (cnt_q == CW'(NBYTES - 1)) state_d = StCheck;
                  else                         cnt_d   = cnt_q + 1'b1;
               end else if ((s_data == sh_csum) && pad_ok) begin
                  state_d = StCommit;
               end else begin
                  frame_fail = 1'b1;
               end
            end else if (gap_q == GW'(GAP_MAX - 1)) begin
               frame_fail = 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         StCommit: begin
            key_d    = sh_key;
            loaded_d = 1'b1;
            fail_d   = '0;
            state_d  = StIdle;
         end
         StLockout: begin
            key_d    = RESET_KEY;
            loaded_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase

      if (frame_fail) begin
         err_d  = 1'b1;
         sh_clr = 1'b1;
         gap_d  = '0;
         cnt_d  = '0;
         fail_d = fail_inc;
         if (fail_inc >= FW'(MAX_FAIL)) begin
            state_d  = StLockout;
            lock_d   = 1'b1;
            key_d    = RESET_KEY;
            loaded_d = 1'b0;
         end else begin
            state_d = StIdle;
         end
      end

      // Registered ready: a pure function of the upcoming state.
      ready_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StCheck);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         gap_q    <= '0;
         fail_q   <= '0;
         key_q    <= RESET_KEY;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         lock_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         fail_q   <= fail_d;
         key_q    <= key_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         lock_q   <= lock_d;
         ready_q  <= ready_d;
      end
   end

   assign s_ready    = ready_q;
   assign key_out    = key_q;
   assign key_loaded = loaded_q;
   assign frame_err  = err_q;
   assign locked_out = lock_q;

endmodule
